wb_host_master: RTL and testbench

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_master.sv | 136 +++++++++++++
 tb/tb_wb_host_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_host_master
//  Description : Command/response to classic Wishbone single-transfer master
//                with per-transaction strobe timeout and transaction/error
//                counters. One transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_host_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    // command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    // response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    // Wishbone master
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    // statistics
    output logic [15:0] txn_count_o,
    output logic [7:0]  err_count_o
);

    // Last timeout-counter value before the strobe is abandoned; the strobe
    // is therefore high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        bus_active;
    logic [7:0]  tmo_cnt;

    // Classic single transfers: cycle and strobe are one and the same.
    assign wbm_cyc_o = bus_active;
    assign wbm_stb_o = bus_active;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            bus_active  <= 1'b0;
            tmo_cnt     <= 8'd0;
            cmd_ready_o <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'd0;
            wbm_adr_o   <= 32'd0;
            wbm_dat_o   <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 32'd0;
            rsp_err_o   <= 1'b0;
            txn_count_o <= 16'd0;
            err_count_o <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        bus_active  <= 1'b1;
                        tmo_cnt     <= 8'd0;
                        cmd_ready_o <= 1'b0;
                        state       <= BUS;
                    end else begin
                        // Ready rises one edge after reset release and
                        // stays up while idle.
                        cmd_ready_o <= 1'b1;
                    end
                end

                BUS: begin
                    // Ack takes priority over a coincident timeout.
                    if (wbm_ack_i) begin
                        bus_active  <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        txn_count_o <= txn_count_o + 16'd1;
                        state       <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus_active  <= 1'b0;
                        rsp_dat_o   <= 32'd0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        txn_count_o <= txn_count_o + 16'd1;
                        if (err_count_o != 8'hFF) begin
                            err_count_o <= err_count_o + 8'd1;
                        end
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    bus_active  <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_host_master
//  Description : Self-checking bench for wb_host_master (TIMEOUT_CYCLES = 4)
//                with a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dato;
    logic        wb_ack;
    logic [31:0] wb_dati;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;
    int exp_txn = 0;
    int exp_err = 0;
    int cyc_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    wb_host_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (wb_cyc),
        .wbm_stb_o  (wb_stb),
        .wbm_we_o   (wb_we),
        .wbm_sel_o  (wb_sel),
        .wbm_adr_o  (wb_adr),
        .wbm_dat_o  (wb_dato),
        .wbm_ack_i  (wb_ack),
        .wbm_dat_i  (wb_dati),
        .txn_count_o(txn_count),
        .err_count_o(err_count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wb_ack = 1'b0; wb_dati = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dato} !== '0) begin
            fails++;
            $display("FAIL reset_wbm: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h expected all 0",
                     wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dato);
        end
        tests++;
        if ({rsp_valid, rsp_err, rsp_dat, cmd_ready} !== '0) begin
            fails++;
            $display("FAIL reset_rsp: got valid=%b err=%b dat=%h ready=%b expected all 0",
                     rsp_valid, rsp_err, rsp_dat, cmd_ready);
        end
        tests++;
        if (txn_count !== 16'd0 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_counts: got txn=%0d err=%0d expected 0 0", txn_count, err_count);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b expected 0", cmd_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: got %b expected 1", cmd_ready);
        end
    endtask

    // One full transaction. ack_cycle = strobe cycle on which the slave acks
    // (0 = never); bp = cycles of response backpressure.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rdat,
                           input int ack_cycle, input int bp, input string name);
        int          n;
        int          exp_stb;
        logic        exp_e;
        logic [31:0] exp_d;
        logic        hold_ok;
        logic        bp_ok;
        exp_e   = !(ack_cycle >= 1 && ack_cycle <= T);
        exp_stb = exp_e ? T : ack_cycle;
        exp_d   = (exp_e || we) ? 32'd0 : rdat;
        exp_txn = (exp_txn + 1) % 65536;
        if (exp_e && exp_err < 255) exp_err++;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: cmd_ready got %b expected 1", name, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

        @(negedge clk);
        n = 0;
        hold_ok = 1'b1;
        while (wb_stb === 1'b1 && n < 300) begin
            n++;
            if (wb_cyc !== 1'b1 || wb_we !== we || wb_adr !== adr || wb_dato !== dat || wb_sel !== sel)
                hold_ok = 1'b0;
            wb_ack  = (n == ack_cycle);
            wb_dati = (n == ack_cycle) ? rdat : $urandom;
            @(negedge clk);
        end
        wb_ack = 1'b0;

        tests++;
        if (!hold_ok) begin
            fails++;
            $display("FAIL %s wbm_hold: bus fields got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                     name, wb_we, wb_adr, wb_dato, wb_sel, we, adr, dat, sel);
        end
        tests++;
        if (n != exp_stb) begin
            fails++;
            $display("FAIL %s stb_cycles: got %0d expected %0d", name, n, exp_stb);
        end
        tests++;
        if (wb_cyc !== 1'b0 || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s rsp_valid: got cyc=%b valid=%b expected cyc=0 valid=1", name, wb_cyc, rsp_valid);
        end
        tests++;
        if (rsp_dat !== exp_d || rsp_err !== exp_e) begin
            fails++;
            $display("FAIL %s rsp: got dat=%h err=%b expected dat=%h err=%b", name, rsp_dat, rsp_err, exp_d, exp_e);
        end
        tests++;
        if (txn_count !== 16'(exp_txn) || err_count !== 8'(exp_err)) begin
            fails++;
            $display("FAIL %s counts: got txn=%0d err=%0d expected txn=%0d err=%0d",
                     name, txn_count, err_count, exp_txn, exp_err);
        end

        bp_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            wb_ack    = 1'($urandom);
            wb_dati   = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== exp_d || rsp_err !== exp_e ||
                cmd_ready !== 1'b0 || wb_stb !== 1'b0 || txn_count !== 16'(exp_txn))
                bp_ok = 1'b0;
        end
        if (bp > 0) begin
            tests++;
            if (!bp_ok) begin
                fails++;
                $display("FAIL %s backpressure: got valid=%b dat=%h err=%b ready=%b stb=%b expected valid=1 dat=%h err=%b ready=0 stb=0",
                         name, rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_stb, exp_d, exp_e);
            end
        end
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_stb !== 1'b0) begin
            fails++;
            $display("FAIL %s release: got valid=%b ready=%b stb=%b expected valid=0 ready=1 stb=0",
                     name, rsp_valid, cmd_ready, wb_stb);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h3000_0000, 32'h0000_0ABC, 4'hF, 32'hDEAD_BEEF, 2, 0, "write");
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h3000_0000, 32'h1234_5678, 4'hF, 32'h0000_0ABC, 1, 0, "read");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h3000_0004, 32'h0, 4'h3, 32'hFFFF_FFFF, 0, 1, "timeout");
        run_txn(1'b1, 32'h3000_0008, 32'h55AA_55AA, 4'hC, 32'h0, 0, 0, "timeout_wr");
    endtask

    task automatic test_ack_at_limit();
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_F00D, T, 0, "ack_last");
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h0BAD_F00D, 3, 5, "backpressure");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                    int'($urandom_range(0, T + 2)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    // Back-to-back with an instant slave and an always-ready consumer:
    // successive accepts are three edges apart.
    task automatic test_back_to_back();
        int acc[2];
        int k;
        k = 0;
        acc[0] = 0; acc[1] = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4000_0000; cmd_sel = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (k == 2) cmd_valid = 1'b0;
            wb_ack  = wb_stb;
            wb_dati = 32'h0000_1111;
            if (cmd_valid && cmd_ready === 1'b1 && k < 2) begin
                acc[k] = cyc_no;
                k++;
            end
            @(negedge clk);
        end
        wb_ack    = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_txn   = (exp_txn + 2) % 65536;
        tests++;
        if (k != 2 || acc[1] - acc[0] != 3) begin
            fails++;
            $display("FAIL b2b_latency: got accepts=%0d spacing=%0d expected accepts=2 spacing=3",
                     k, acc[1] - acc[0]);
        end
        tests++;
        if (txn_count !== 16'(exp_txn) || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_counts: got txn=%0d valid=%b expected txn=%0d valid=0",
                     txn_count, rsp_valid, exp_txn);
        end
    endtask

    task automatic test_reset_mid_bus();
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h5000_0000; cmd_dat = 32'h1; cmd_sel = 4'h1;
        n = 0;
        while (wb_stb !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (wb_stb !== 1'b1) begin
            fails++;
            $display("FAIL mid_bus_setup: stb got %b expected 1", wb_stb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_txn = 0;
        exp_err = 0;
        tests++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_bus_reset: got cyc=%b stb=%b valid=%b ready=%b expected all 0",
                     wb_cyc, wb_stb, rsp_valid, cmd_ready);
        end
        tests++;
        if (txn_count !== 16'd0 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL mid_bus_counts: got txn=%0d err=%0d expected 0 0", txn_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_stb !== 1'b0) begin
            fails++;
            $display("FAIL mid_bus_release: got ready=%b valid=%b stb=%b expected 1 0 0",
                     cmd_ready, rsp_valid, wb_stb);
        end
        run_txn(1'b0, 32'h5000_0004, 32'h0, 4'hF, 32'h7777_0000, 2, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
